ov5640_size_cfg_seq: RTL

Sequences the OV5640 output-size and timing registers (DVP H/V output size, HTS, VTS) over the SCCB/I2C driver. It runs after the base init table and re-runs automatically whenever the selected resolution or frame timing changes, for example on an LCD ID change. It sits between the picture-size selection logic and the shared i2c_dri command port, and it uses a group-hold write so the sensor applies all eight timing bytes atomically.

---
 rtl/ov5640_size_cfg_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ov5640_size_cfg_seq.sv
// OV5640 output-size / frame-timing register sequencer.
// Writes DVP H/V size, HTS and VTS inside a group-hold (group 3) over the
// shared i2c_dri command port. It re-runs whenever the live size inputs
// differ from the snapshot that was last written.
module ov5640_size_cfg_seq #(
    parameter int unsigned INIT_DLY  = 20000,
    parameter int unsigned TIMEOUT   = 65535,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic [12:0] cmos_h_pixel,
    input  logic [12:0] cmos_v_pixel,
    input  logic [12:0] total_h_pixel,
    input  logic [12:0] total_v_pixel,
    input  logic        i2c_done,
    output logic        i2c_exec,
    output logic [23:0] i2c_data,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [3:0]  cfg_idx
);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_START,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    state_t      state;
    logic [31:0] dly_cnt;
    logic [31:0] to_cnt;
    logic [31:0] retry_cnt;
    logic [12:0] snap_h;
    logic [12:0] snap_v;
    logic [12:0] snap_hts;
    logic [12:0] snap_vts;
    logic        sizes_changed;

    // Register/value pair for one table index; sizes come from the snapshot.
    function automatic logic [23:0] table_entry(
        input logic [3:0]  idx,
        input logic [12:0] h,
        input logic [12:0] v,
        input logic [12:0] hts,
        input logic [12:0] vts
    );
        logic [23:0] e;
        case (idx)
            4'd0:    e = 24'h321203;
            4'd1:    e = {16'h3808, 3'b000, h[12:8]};
            4'd2:    e = {16'h3809, h[7:0]};
            4'd3:    e = {16'h380A, 3'b000, v[12:8]};
            4'd4:    e = {16'h380B, v[7:0]};
            4'd5:    e = {16'h380C, 3'b000, hts[12:8]};
            4'd6:    e = {16'h380D, hts[7:0]};
            4'd7:    e = {16'h380E, 3'b000, vts[12:8]};
            4'd8:    e = {16'h380F, vts[7:0]};
            4'd9:    e = 24'h321213;
            4'd10:   e = 24'h3212A3;
            default: e = '0;
        endcase
        return e;
    endfunction

    // Live size inputs differ from what was last written to the sensor.
    always_comb begin
        sizes_changed = (cmos_h_pixel  != snap_h)   ||
                        (cmos_v_pixel  != snap_v)   ||
                        (total_h_pixel != snap_hts) ||
                        (total_v_pixel != snap_vts);
    end

    // Sequencer FSM; all outputs registered. i2c_exec is high for exactly
    // the ISSUE cycle, because it is set only on transitions into ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_WAIT_INIT;
            dly_cnt   <= '0;
            to_cnt    <= '0;
            retry_cnt <= '0;
            snap_h    <= '0;
            snap_v    <= '0;
            snap_hts  <= '0;
            snap_vts  <= '0;
            i2c_exec  <= 1'b0;
            i2c_data  <= '0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_idx   <= '0;
        end else begin
            i2c_exec <= 1'b0;
            case (state)
                S_WAIT_INIT: begin
                    if (!init_done) begin
                        dly_cnt <= '0;
                    end else if (dly_cnt == INIT_DLY - 1) begin
                        dly_cnt <= '0;
                        state   <= S_START;
                    end else begin
                        dly_cnt <= dly_cnt + 32'd1;
                    end
                end
                S_START: begin
                    snap_h    <= cmos_h_pixel;
                    snap_v    <= cmos_v_pixel;
                    snap_hts  <= total_h_pixel;
                    snap_vts  <= total_v_pixel;
                    cfg_idx   <= '0;
                    cfg_busy  <= 1'b1;
                    cfg_done  <= 1'b0;
                    retry_cnt <= '0;
                    i2c_data  <= table_entry(4'd0, snap_h, snap_v, snap_hts, snap_vts);
                    i2c_exec  <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (i2c_done) begin
                        retry_cnt <= '0;
                        if (cfg_idx == LAST_IDX) begin
                            cfg_busy <= 1'b0;
                            cfg_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            cfg_idx  <= cfg_idx + 4'd1;
                            i2c_data <= table_entry(cfg_idx + 4'd1, snap_h, snap_v,
                                                    snap_hts, snap_vts);
                            i2c_exec <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end else if (to_cnt == TIMEOUT - 1) begin
                        if (retry_cnt < MAX_RETRY) begin
                            retry_cnt <= retry_cnt + 32'd1;
                            i2c_exec  <= 1'b1;
                            state     <= S_ISSUE;
                        end else begin
                            cfg_err  <= 1'b1;
                            cfg_busy <= 1'b0;
                            state    <= S_ERROR;
                        end
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    if (sizes_changed) begin
                        state <= S_START;
                    end
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state <= S_WAIT_INIT;
                end
            endcase
        end
    end

endmodule
